maxnet_controller: RTL



---
 rtl/maxnet_pkg.sv | 20 ++
 rtl/maxnet_watchdog.sv | 29 ++
 rtl/maxnet_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and default constants for the Maxnet sequencing controller.
// Optional watchdog is enabled with MAXNET_CTRL_WATCHDOG_EN.
package maxnet_pkg;

  localparam int unsigned ITER_W        = 8;
  localparam int unsigned MAX_ITER_DEF  = 64;
  localparam int unsigned WD_CYCLES_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_UPD,
    S_CHK,
    S_FIN
  } state_t;

endpackage

// File: rtl/maxnet_watchdog.sv
// WAIT-state cycle counter; expired is high in the WD_CYCLES-th consecutive
// cycle of en. Only instantiated when MAXNET_CTRL_WATCHDOG_EN is defined.
module maxnet_watchdog
  import maxnet_pkg::*;
#(
  parameter int unsigned WD_CYCLES = WD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(WD_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Restarts every time the controller leaves WAIT.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt == CW'(WD_CYCLES - 1));

endmodule

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the four-neuron Maxnet datapath (load, clear, start,
// wait, write back, check). Define MAXNET_CTRL_WATCHDOG_EN to add the WAIT watchdog.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned MAX_ITER  = MAX_ITER_DEF,
  parameter int unsigned WD_CYCLES = WD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              plu_done,
  input  logic              finish,
  output logic              mux_sel,
  output logic              we_prim,
  output logic              we_a_reg,
  output logic              rst_plu,
  output logic              plu_start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              wd_err,
  output logic [ITER_W-1:0] iter
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_nxt;
  logic   wd_expired;

`ifdef MAXNET_CTRL_WATCHDOG_EN
  maxnet_watchdog #(
    .WD_CYCLES(WD_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state == S_WAIT),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are decoded from the current state only, so no input reaches an output.
  always_comb begin
    state_nxt = state;
    mux_sel   = 1'b0;
    we_prim   = 1'b0;
    we_a_reg  = 1'b0;
    rst_plu   = 1'b0;
    plu_start = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        we_prim   = 1'b1;
        we_a_reg  = 1'b1;
        state_nxt = S_CLR;
      end
      S_CLR: begin
        rst_plu   = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        plu_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (plu_done) state_nxt = S_UPD;
        else if (wd_expired) state_nxt = S_FIN;
      end
      S_UPD: begin
        mux_sel   = 1'b1;
        we_a_reg  = 1'b1;
        state_nxt = S_CHK;
      end
      S_CHK: begin
        if (finish || (iter == ITER_LIMIT)) state_nxt = S_FIN;
        else state_nxt = S_CLR;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter    <= '0;
      timeout <= 1'b0;
      wd_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            iter    <= '0;
            timeout <= 1'b0;
            wd_err  <= 1'b0;
          end
        end
        S_UPD: begin
          if (iter != ITER_LIMIT) iter <= iter + ITER_W'(1);
        end
        S_CHK: begin
          if (!finish && (iter == ITER_LIMIT)) timeout <= 1'b1;
        end
        S_WAIT: begin
          if (wd_expired && !plu_done) wd_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
